// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: default timing, mode
// encoding and the colour-bar lookup.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int POS_W    = 10;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAY  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Returns {G,R,B}; bar 0 is white and bar 7 is black.
    function automatic logic [2:0] bar_code(input logic [2:0] idx);
        return 3'd7 - idx;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a programmable reset value.
module vga_delay_line #(
    parameter int           W       = 1,
    parameter int           DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: bars, checker, grey ramp, solid.
// Two-stage pipeline; syncs are delay-matched to the registered RGB.
module vga_pattern_gen #(
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   POS_W      = vga_pkg::POS_W,
    parameter int   COLOR_W    = 4,
    parameter int   NUM_BARS   = 8,
    parameter int   CHECK_LOG2 = 5,
    parameter int   BLINK_LOG2 = 5,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [POS_W-1:0]     hpos,
    input  logic [POS_W-1:0]     vpos,
    input  logic                 display_on,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic [1:0]           mode,
    input  logic                 blink_en,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic [15:0]          frame_cnt
);
    import vga_pkg::*;

    localparam int               BAR_W     = H_ACTIVE / NUM_BARS;
    localparam int               GRAD_STEP = H_ACTIVE >> COLOR_W;
    localparam logic [POS_W-1:0] BAR_LAST  = POS_W'(NUM_BARS - 1);
    localparam logic [POS_W-1:0] BAR_W_M1  = POS_W'(BAR_W - 1);
    localparam logic [POS_W-1:0] GRAD_M1   = POS_W'(GRAD_STEP - 1);

    function automatic logic [COLOR_W-1:0] sat_level(input logic [COLOR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] sat_bar(input logic [POS_W-1:0] v);
        return (v >= BAR_LAST) ? BAR_LAST : v + 1'b1;
    endfunction

    logic                 line_start, fs, in_h, act_p0, vld_p0;
    mode_e                mode_q, mode_eff;
    logic                 blink_q, blink_eff, phase_bit, armed_q;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [3*COLOR_W-1:0] solid_q, solid_eff;

    assign line_start  = (hpos == '0);
    assign fs          = line_start && (vpos == '0);
    assign in_h        = hpos < POS_W'(H_ACTIVE);
    assign act_p0      = display_on && in_h && (vpos < POS_W'(V_ACTIVE));
    assign frame_cnt_d = frame_cnt_q + 16'd1;

    // Settings take effect on the frame-start pixel itself, not one pixel late.
    assign mode_eff  = fs ? mode_e'(mode) : mode_q;
    assign blink_eff = fs ? blink_en : blink_q;
    assign solid_eff = fs ? solid_rgb : solid_q;
    assign phase_bit = fs ? frame_cnt_d[BLINK_LOG2] : frame_cnt_q[BLINK_LOG2];
    assign vld_p0    = fs || armed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_BARS;
            blink_q     <= 1'b0;
            frame_cnt_q <= '0;
            armed_q     <= 1'b0;
        end else if (fs) begin
            mode_q      <= mode_e'(mode);
            blink_q     <= blink_en;
            frame_cnt_q <= frame_cnt_d;
            armed_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fs) solid_q <= solid_rgb;
    end

    logic [POS_W-1:0]   pix_q, pix_d, pix_cur, bar_q, bar_d, bar_cur;
    logic [POS_W-1:0]   gpix_q, gpix_d, gpix_cur;
    logic [COLOR_W-1:0] lvl_q, lvl_d, lvl_cur;

    always_comb begin
        pix_cur  = line_start ? '0 : pix_q;
        bar_cur  = line_start ? '0 : bar_q;
        gpix_cur = line_start ? '0 : gpix_q;
        lvl_cur  = line_start ? '0 : lvl_q;
        pix_d    = pix_cur;
        bar_d    = bar_cur;
        gpix_d   = gpix_cur;
        lvl_d    = lvl_cur;
        if (in_h) begin
            if (pix_cur >= BAR_W_M1) begin
                pix_d = '0;
                bar_d = sat_bar(bar_cur);
            end else begin
                pix_d = pix_cur + 1'b1;
            end
            if (gpix_cur >= GRAD_M1) begin
                gpix_d = '0;
                lvl_d  = sat_level(lvl_cur);
            end else begin
                gpix_d = gpix_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        pix_q  <= pix_d;
        bar_q  <= bar_d;
        gpix_q <= gpix_d;
        lvl_q  <= lvl_d;
    end

    logic [2:0]           code;
    logic                 ck_on;
    logic [COLOR_W-1:0]   ck_ch;
    logic [3*COLOR_W-1:0] col_p0;

    always_comb begin
        code   = bar_code(bar_cur[2:0]);
        ck_on  = hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2] ^ (blink_eff & phase_bit);
        ck_ch  = {COLOR_W{ck_on}};
        col_p0 = solid_eff;
        case (mode_eff)
            MODE_BARS:  col_p0 = {{COLOR_W{code[1]}}, {COLOR_W{code[2]}}, {COLOR_W{code[0]}}};
            MODE_CHECK: col_p0 = {ck_ch, ck_ch, ck_ch};
            MODE_GRAY:  col_p0 = {lvl_cur, lvl_cur, lvl_cur};
            default:    col_p0 = solid_eff;
        endcase
    end

    // ---- stage 1: pattern colour, active and valid ----
    logic [3*COLOR_W-1:0] col_p1_q;
    logic                 vld_p1, act_p1;

    always_ff @(posedge clk) begin
        col_p1_q <= col_p0;
    end

    vga_delay_line #(.W(2), .DEPTH(1), .RST_VAL(2'b00)) u_act_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   ({vld_p0, act_p0}),
        .q_o   ({vld_p1, act_p1})
    );

    // ---- stage 2: registered outputs ----
    logic [3*COLOR_W-1:0] rgb_p2_q;

    always_ff @(posedge clk) begin
        if (reset) rgb_p2_q <= '0;
        else       rgb_p2_q <= (vld_p1 && act_p1) ? col_p1_q : '0;
    end

    vga_delay_line #(.W(2), .DEPTH(2), .RST_VAL({SYNC_IDLE, SYNC_IDLE})) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   ({hsync_in, vsync_in}),
        .q_o   ({hsync_out, vsync_out})
    );

    assign vga_r     = rgb_p2_q[3*COLOR_W-1:2*COLOR_W];
    assign vga_g     = rgb_p2_q[2*COLOR_W-1:COLOR_W];
    assign vga_b     = rgb_p2_q[COLOR_W-1:0];
    assign frame_cnt = frame_cnt_q;

endmodule
